// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } read_mode_e;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty levels and an occupancy count.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 16,
  parameter int unsigned  FIFO_DEPTH = 8,
  parameter int unsigned  AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned  AE_LEVEL   = 1,
  parameter read_mode_e   READ_MODE  = FIFO_STD,
  localparam int unsigned CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_prog: FIFO_DEPTH must be a power of two and >= 4");
  end
  if (AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_prog: AF_LEVEL must not exceed FIFO_DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $fatal(1, "sync_fifo_prog: AE_LEVEL must be below AF_LEVEL");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_go;
  logic                  rd_go;

  assign wr_go = wr_en & ~full;
  assign rd_go = rd_en & ~empty;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_CNT);
  assign almostempty = (count != '0) && (count <= AE_CNT);

  // Write enable is masked during reset so a request in the reset cycle leaves memory untouched.
  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_go & ~rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_go, rd_go})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_go;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  if (READ_MODE == FIFO_STD) begin : g_std
    always_ff @(posedge clk) begin
      if (rst) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else if (rd_go) begin
        data_out   <= rdata;
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end
    end
  end else begin : g_fwft
    // Head word is presented directly; masked while empty so reset shows a zero word.
    assign data_out   = empty ? '0 : rdata;
    assign data_valid = ~empty;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-mode and a FWFT-mode FIFO with identical stimulus and checks both against a queue model.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned AF    = 7;
  localparam int unsigned AE    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, f_dv, s_ack, f_ack, s_ovf, f_ovf, s_udf, f_udf;
  logic          s_full, f_full, s_empty, f_empty, s_af, f_af, s_ae, f_ae;
  logic [CW-1:0] s_count, f_count;

  sync_fifo_prog #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .READ_MODE (FIFO_STD)
  ) u_std (
    .clk (clk), .rst (rst), .wr_en (wr_en), .rd_en (rd_en), .data_in (data_in),
    .data_out (s_dout), .data_valid (s_dv), .wr_ack (s_ack), .overflow (s_ovf),
    .underflow (s_udf), .full (s_full), .empty (s_empty), .almostfull (s_af),
    .almostempty (s_ae), .count (s_count)
  );

  sync_fifo_prog #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .READ_MODE (FIFO_FWFT)
  ) u_fwft (
    .clk (clk), .rst (rst), .wr_en (wr_en), .rd_en (rd_en), .data_in (data_in),
    .data_out (f_dout), .data_valid (f_dv), .wr_ack (f_ack), .overflow (f_ovf),
    .underflow (f_udf), .full (f_full), .empty (f_empty), .almostfull (f_af),
    .almostempty (f_ae), .count (f_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model: the FIFO contents as a queue plus the expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_dv, m_ack, m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    int unsigned n;
    logic wgo, rgo;
    n = q.size();
    if (r) begin
      q.delete();
      m_dout = '0; m_dv = 1'b0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      wgo   = w && (n < DEPTH);
      rgo   = rd && (n > 0);
      m_ack = wgo;
      m_ovf = w && !wgo;
      m_udf = rd && !rgo;
      m_dv  = rgo;
      if (rgo) m_dout = q.pop_front();
      if (wgo) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    check("s.count", 32'(s_count), n);
    check("s.empty", 32'(s_empty), 32'(n == 0));
    check("s.full",  32'(s_full),  32'(n == DEPTH));
    check("s.af",    32'(s_af),    32'(n >= AF));
    check("s.ae",    32'(s_ae),    32'(n > 0 && n <= AE));
    check("s.ack",   32'(s_ack),   32'(m_ack));
    check("s.ovf",   32'(s_ovf),   32'(m_ovf));
    check("s.udf",   32'(s_udf),   32'(m_udf));
    check("s.dout",  32'(s_dout),  32'(m_dout));
    check("s.dv",    32'(s_dv),    32'(m_dv));
    check("f.count", 32'(f_count), n);
    check("f.full",  32'(f_full),  32'(n == DEPTH));
    check("f.ack",   32'(f_ack),   32'(m_ack));
    check("f.ovf",   32'(f_ovf),   32'(m_ovf));
    check("f.udf",   32'(f_udf),   32'(m_udf));
    check("f.dv",    32'(f_dv),    32'(n > 0));
    if (n > 0) check("f.dout", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    model_edge(r, w, rd, d);
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hFFFF;
    m_dout = '0; m_dv = 1'b0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);

    // Reset held two cycles with both requests active.
    step(1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF);
    check("rst.empty", 32'(s_empty), 32'd1);
    check("rst.dout",  32'(s_dout),  32'd0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(16'hA001 + i));
      if (i == 6) check("fill.af_at7", 32'(s_af), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 16'hDEAD);
    check("fill.ovf9", 32'(s_ovf), 32'd1);
    check("fill.cnt8", 32'(s_count), 32'd8);

    // Drain in order, one rejected read holds the last word.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check("drain.dout", 32'(s_dout), 32'(16'hA001 + i));
    end
    step(1'b0, 1'b0, 1'b1, '0);
    check("drain.udf", 32'(s_udf), 32'd1);
    check("drain.hold", 32'(s_dout), 32'h0000A008);

    // Simultaneous requests at the full and empty boundaries.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DW'(16'hC000 + i));
    step(1'b0, 1'b1, 1'b1, 16'hC0DE);
    check("both_full.cnt", 32'(s_count), 32'd7);
    check("both_full.ovf", 32'(s_ovf), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, 16'h5A5A);
    check("both_empty.cnt", 32'(s_count), 32'd1);
    check("both_empty.udf", 32'(s_udf), 32'd1);
    check("both_empty.ack", 32'(s_ack), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0);

    // Pointer wrap with alternating single writes and reads.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(16'hB000 + i));
      step(1'b0, 1'b0, 1'b1, '0);
      check("wrap.dout", 32'(s_dout), 32'(16'hB000 + i));
    end

    // FWFT head visibility, pop, and reset with data stored.
    step(1'b0, 1'b1, 1'b0, 16'h1234);
    check("fwft.dv",   32'(f_dv),   32'd1);
    check("fwft.dout", 32'(f_dout), 32'h00001234);
    step(1'b0, 1'b0, 1'b1, '0);
    check("fwft.empty", 32'(f_empty), 32'd1);
    check("fwft.dv0",   32'(f_dv),    32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(16'h7700 + i));
    step(1'b1, 1'b0, 1'b0, '0);
    check("fwft.rst_cnt",   32'(f_count), 32'd0);
    check("fwft.rst_empty", 32'(f_empty), 32'd1);

    // Random traffic, alternating write-heavy and read-heavy phases to reach both limits.
    for (int i = 0; i < 600; i++) begin
      int unsigned wp;
      logic r, w, rd;
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(99) < 2);
      w  = ($urandom_range(99) < wp);
      rd = ($urandom_range(99) < (100 - wp));
      step(r, w, rd, DW'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
